// File: rtl/display_7seg.sv
// Single-digit seven-segment driver with lamp test, blanking and ripple-blanking.
// Segment order on the internal vector is {a,b,c,d,e,f,g}, a in the MSB.
module display_7seg #(
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter bit HEX_EN         = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  input  logic       dp_in,
  input  logic       blank,
  input  logic       lamp_test,
  input  logic       rbi,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp,
  output logic       rbo
);

  localparam int unsigned SEG_W = 7;

  logic [SEG_W-1:0] glyph_c;
  logic [SEG_W-1:0] seg_lit_c;
  logic             dp_lit_c;
  logic [SEG_W-1:0] seg_d, seg_q;
  logic             dp_d, dp_q;
  logic             rbo_d, rbo_q;

  // Active-high glyph lookup
  always_comb begin
    glyph_c = '0;
    unique case (data)
      4'd0:    glyph_c = 7'b1111110;
      4'd1:    glyph_c = 7'b0110000;
      4'd2:    glyph_c = 7'b1101101;
      4'd3:    glyph_c = 7'b1111001;
      4'd4:    glyph_c = 7'b0110011;
      4'd5:    glyph_c = 7'b1011011;
      4'd6:    glyph_c = 7'b1011111;
      4'd7:    glyph_c = 7'b1110000;
      4'd8:    glyph_c = 7'b1111111;
      4'd9:    glyph_c = 7'b1111011;
      4'd10:   glyph_c = HEX_EN ? 7'b1110111 : 7'b0000001;
      4'd11:   glyph_c = HEX_EN ? 7'b0011111 : 7'b0000001;
      4'd12:   glyph_c = HEX_EN ? 7'b1001110 : 7'b0000001;
      4'd13:   glyph_c = HEX_EN ? 7'b0111101 : 7'b0000001;
      4'd14:   glyph_c = HEX_EN ? 7'b1001111 : 7'b0000001;
      default: glyph_c = HEX_EN ? 7'b1000111 : 7'b0000001;
    endcase
  end

  // Override priority: blank > lamp test > ripple blank > normal decode
  always_comb begin
    seg_lit_c = glyph_c;
    dp_lit_c  = dp_in;
    rbo_d     = 1'b0;
    if (blank) begin
      seg_lit_c = '0;
      dp_lit_c  = 1'b0;
    end else if (lamp_test) begin
      seg_lit_c = '1;
      dp_lit_c  = 1'b1;
    end else if (rbi && (data == 4'd0)) begin
      seg_lit_c = '0;
      rbo_d     = 1'b1;
    end
  end

  // Polarity applied only at the register input; rbo stays active-high
  always_comb begin
    seg_d = seg_lit_c ^ {SEG_W{ACTIVE_LOW_SEG}};
    dp_d  = dp_lit_c ^ ACTIVE_LOW_SEG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= {SEG_W{ACTIVE_LOW_SEG}};
      dp_q  <= ACTIVE_LOW_SEG;
      rbo_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      rbo_q <= rbo_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp  = dp_q;
  assign rbo = rbo_q;

endmodule

// File: tb/tb_display_7seg.sv
// Directed bench for display_7seg: default, hex-disabled and active-low instances
// share one stimulus and are compared against hand-computed segment patterns.
module tb_display_7seg;

  logic       clk;
  logic       rst_n;
  logic [3:0] data;
  logic       dp_in, blank, lamp_test, rbi;

  logic a0, b0, c0, d0, e0, f0, g0, dp0, rbo0;
  logic a1, b1, c1, d1, e1, f1, g1, dp1, rbo1;
  logic a2, b2, c2, d2, e2, f2, g2, dp2, rbo2;

  int n_checks = 0;
  int n_errs   = 0;

  logic [6:0] exp_tab [16];

  display_7seg #(.ACTIVE_LOW_SEG(1'b0), .HEX_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .blank(blank),
    .lamp_test(lamp_test), .rbi(rbi),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .dp(dp0), .rbo(rbo0)
  );

  display_7seg #(.ACTIVE_LOW_SEG(1'b0), .HEX_EN(1'b0)) u_nohex (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .blank(blank),
    .lamp_test(lamp_test), .rbi(rbi),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .dp(dp1), .rbo(rbo1)
  );

  display_7seg #(.ACTIVE_LOW_SEG(1'b1), .HEX_EN(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .blank(blank),
    .lamp_test(lamp_test), .rbi(rbi),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2), .dp(dp2), .rbo(rbo2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] obs0();
    return {a0, b0, c0, d0, e0, f0, g0, dp0, rbo0};
  endfunction
  function automatic logic [8:0] obs1();
    return {a1, b1, c1, d1, e1, f1, g1, dp1, rbo1};
  endfunction
  function automatic logic [8:0] obs2();
    return {a2, b2, c2, d2, e2, f2, g2, dp2, rbo2};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got {seg,dp,rbo}=%b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs, clock once, then check all three instances.
  // Hex-disabled instance lights g only for 10..15 on the normal-decode path.
  task automatic step(input string tag, input logic [3:0] dv, input logic dpi,
                      input logic bl, input logic lt, input logic rb,
                      input logic [6:0] es, input logic edp, input logic erbo);
    logic [6:0] es_nohex;
    data = dv; dp_in = dpi; blank = bl; lamp_test = lt; rbi = rb;
    @(posedge clk); #1;
    es_nohex = (dv >= 4'd10 && !bl && !lt) ? 7'b0000001 : es;
    check({tag, "/hi"},    obs0(), {es, edp, erbo});
    check({tag, "/nohex"}, obs1(), {es_nohex, edp, erbo});
    check({tag, "/lo"},    obs2(), {~es, ~edp, erbo});
  endtask

  initial begin
    exp_tab[0]  = 7'b1111110; exp_tab[1]  = 7'b0110000;
    exp_tab[2]  = 7'b1101101; exp_tab[3]  = 7'b1111001;
    exp_tab[4]  = 7'b0110011; exp_tab[5]  = 7'b1011011;
    exp_tab[6]  = 7'b1011111; exp_tab[7]  = 7'b1110000;
    exp_tab[8]  = 7'b1111111; exp_tab[9]  = 7'b1111011;
    exp_tab[10] = 7'b1110111; exp_tab[11] = 7'b0011111;
    exp_tab[12] = 7'b1001110; exp_tab[13] = 7'b0111101;
    exp_tab[14] = 7'b1001111; exp_tab[15] = 7'b1000111;

    rst_n = 1'b0; data = 4'd8; dp_in = 1'b0; blank = 1'b0; lamp_test = 1'b0; rbi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/hi", obs0(), 9'b0000000_0_0);
    check("reset/lo", obs2(), 9'b1111111_1_0);

    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel/hi", obs0(), 9'b1111111_0_0);
    check("rel/lo", obs2(), 9'b0000000_1_0);

    for (int i = 0; i < 16; i++)
      step($sformatf("dec%0d", i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, exp_tab[i], 1'b0, 1'b0);

    // Output holds until the next edge even after inputs change
    data = 4'd1;
    #2;
    check("latency/hold", obs0(), {exp_tab[15], 1'b0, 1'b0});
    @(posedge clk); #1;
    check("latency/next", obs0(), {exp_tab[1], 1'b0, 1'b0});

    step("dp_on",      4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111111, 1'b1, 1'b0);
    step("lamp",       4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1111111, 1'b1, 1'b0);
    step("blank_lamp", 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000000, 1'b0, 1'b0);
    step("blank_rbi",  4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b0000000, 1'b0, 1'b0);
    step("lamp_rbi",   4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1111111, 1'b1, 1'b0);
    step("rb_zero",    4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000, 1'b1, 1'b1);
    step("rb_zero_nd", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 1'b0, 1'b1);
    step("rb_five",    4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1011011, 1'b0, 1'b0);
    step("zero_norbi", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111110, 1'b0, 1'b0);
    step("rb_hex",     4'd12, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1001110, 1'b1, 1'b0);

    // Leave rbo high, then reset mid-cycle: outputs must clear without a clock edge
    step("pre_rst",    4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst/hi", obs0(), 9'b0000000_0_0);
    check("async_rst/lo", obs2(), 9'b1111111_1_0);
    @(negedge clk);
    // Input change coincident with reset release is captured on the first edge
    rst_n = 1'b1; data = 4'd7; dp_in = 1'b0; rbi = 1'b0;
    @(posedge clk); #1;
    check("rel_change/hi", obs0(), {exp_tab[7], 1'b0, 1'b0});
    check("rel_change/lo", obs2(), {~exp_tab[7], 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/display_7seg.md
Name: display_7seg

Overview:
- Single-digit seven-segment display driver: decodes a 4-bit value into segment lines a..g plus decimal point dp.
- Sits between datapath/BCD logic and the board's seven-segment pins.
- Adds lamp test, blanking and ripple-blanking (leading-zero suppression).
- Outputs are registered, so the pins are glitch-free.

Parameters:
- ACTIVE_LOW_SEG, 0, 1 = segment/dp outputs are active-low (common-anode board); 0 = active-high.
- HEX_EN, 1, 1 = codes 10..15 show A,b,C,d,E,F; 0 = codes 10..15 show a dash (only g lit).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data  input  4  value to display, 0..15.
- dp_in  input  1  1 = light decimal point.
- blank  input  1  1 = force all segments and dp off (highest priority).
- lamp_test  input  1  1 = force all segments and dp on.
- rbi  input  1  ripple-blank in; 1 = suppress a zero on this digit.
- a, b, c, d, e, f, g  output  1 each  segment drives, registered, polarity per ACTIVE_LOW_SEG.
- dp  output  1  decimal point drive, registered, polarity per ACTIVE_LOW_SEG.
- rbo  output  1  ripple-blank out, registered, active-high; 1 = this digit was zero-suppressed.

Behaviour:
- Reset (rst_n=0, asynchronous): all segments and dp go to the inactive level (0 if ACTIVE_LOW_SEG=0, 1 otherwise); rbo=0. Reset held until rst_n rises; the first decode is registered on the next clk edge after release.
- Latency: inputs are sampled on each rising clk; outputs reflect those inputs after exactly 1 cycle. No handshake; a new value is accepted every cycle.
- Internal logic is active-high. Polarity inversion is applied only at the output register input when ACTIVE_LOW_SEG=1. rbo is never inverted.
- Priority, highest first:
  - blank=1: all segments and dp off; rbo=0.
  - lamp_test=1: all segments and dp on; rbo=0.
  - rbi=1 and data==0: all segments off; dp follows dp_in; rbo=1.
  - Otherwise: normal decode; dp=dp_in; rbo=0.
- Decode table (lit segments, active-high):
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc; 8 abcdefg; 9 abcdfg.
  - HEX_EN=1: 10 abcefg (A); 11 cdefg (b); 12 adef (C); 13 bcdeg (d); 14 adefg (E); 15 aefg (F).
  - HEX_EN=0: codes 10..15 light g only.
- Boundary conditions:
  - rbi=1 with data!=0 displays normally, rbo=0.
  - blank and lamp_test both 1: blank wins.
  - An input change in the same cycle as rst_n deassertion is sampled normally on the first edge.
  - Reset asserted mid-operation forces outputs inactive immediately, without waiting for clk.
- Purely synchronous apart from the reset; no internal state beyond the output registers.

Test Plan:
- Reset: rst_n=0 with data=8 and clk running -> a..g,dp all 0 (ACTIVE_LOW_SEG=0), rbo=0; release rst_n -> next edge gives all segments 1.
- Sweep: data=0..9 one per cycle, dp_in=0 -> 1 cycle later {a..g} = 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011; dp=0.
- Hex: HEX_EN=1, data=10..15 -> 1110111, 0011111, 1001110, 0111101, 1001111, 1000111. With HEX_EN=0, data=12 -> 0000001.
- Override priority: data=3, lamp_test=1 -> all 1 including dp; add blank=1 -> all 0, rbo=0.
- Ripple blanking: rbi=1, data=0, dp_in=1 -> segments 0000000, dp=1, rbo=1; rbi=1, data=5 -> 1011011, rbo=0.
- Polarity: ACTIVE_LOW_SEG=1, data=1 -> {a..g}=1001111, dp=1; during reset all outputs =1.
